mem_req_arbiter: RTL
====================

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 Parameter NCH, default 2, number of requesting channels (ch0 = instruction fetch, ch1 = data); legal range 2..8.
REQ-002 Parameter AW, default 32, address width.
REQ-003 Parameter DW, default 32, data width.
REQ-004 Parameter DEPTH, default 4, maximum outstanding accepted requests; power of two, 2..16.
REQ-005 Parameter RR, default 1: 1 = round-robin, 0 = fixed priority with lowest channel index winning.
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 resetn  input  1  reset, asynchronous and active-low.
REQ-008 m_req  input  NCH  per-channel request valid.
REQ-009 m_wr  input  NCH  per-channel write flag.
REQ-010 m_size  input  2*NCH  per-channel access size: 0 = byte, 1 = half, 2 = word.
REQ-011 m_addr  input  AW*NCH  per-channel address.
REQ-012 m_wdata  input  DW*NCH  per-channel write data.
REQ-013 m_addr_ok  output  NCH  request accepted, one-hot or zero.
REQ-014 m_data_ok  output  NCH  response returned, one-hot or zero.
REQ-015 m_rdata  output  DW  read data, broadcast to all channels.
REQ-016 s_req, s_wr, s_size[1:0], s_addr[AW-1:0], s_wdata[DW-1:0]  output  downstream request.
REQ-017 s_addr_ok, s_data_ok  input  1  downstream handshakes; s_rdata  input  DW.
REQ-018 busy  output  1  outstanding count is nonzero.
REQ-019 proto_err  output  1  sticky flag: s_data_ok arrived with nothing outstanding.

Function
REQ-020 Accept: an accept occurs when s_req and s_addr_ok are both high in the same cycle; m_addr_ok of the granted channel is high only in that cycle.
REQ-021 Grant selection, unlocked: combinational over m_req, RR or fixed priority.
- Round-robin search starts at rr_ptr.
- rr_ptr <= granted index + 1 (mod NCH) on each accept.
REQ-022 Lock: once s_req is high without s_addr_ok, the grant is registered and held until accept.
- s_addr, s_wr, s_size and s_wdata follow the locked channel and do not switch.
- Lock clears on accept.
REQ-023 s_req = (locked, or any m_req) AND count < DEPTH; gated low when count == DEPTH, even if a pop occurs in that same cycle.
REQ-024 Ordering FIFO: each accept pushes the granted channel id ($clog2(NCH) bits).
REQ-025 Response: s_data_ok with count > 0 pops the FIFO head.
- m_data_ok[head] = 1 in the same cycle (combinational, zero latency).
- m_rdata = s_rdata.
REQ-026 Simultaneous push and pop in one cycle: count unchanged, both pointers advance.
REQ-027 s_data_ok with count == 0: no pop, all m_data_ok stay 0, proto_err set to 1 until reset.
REQ-028 Pointer wrap: read and write pointers wrap modulo DEPTH; count is 0..DEPTH.
REQ-029 Latency: request path and response path both combinational; no added cycles.
REQ-030 Same-cycle accept and response of one transaction is legal; it is handled as REQ-026.

Reset
REQ-031 Asserting resetn low, including mid-transaction, immediately clears:
- count, FIFO pointers, lock, rr_ptr = 0, proto_err = 0.
- All outputs go to 0; responses in flight are discarded.
REQ-032 The first request is arbitrated in the first cycle after resetn deasserts.

Structure
REQ-033 Shared package holds the size encodings (SZ_BYTE/SZ_HALF/SZ_WORD) and the channel-id-width function; the core top imports it.
REQ-034 One sub-module, id_fifo (parameters DEPTH and id width; push/pop/full/empty/count), holds the ordering FIFO; the arbiter logic stays in mem_req_arbiter.

Verification
REQ-035 NCH=2, RR=1; both channels request continuously; s_addr_ok=1 -> grants alternate ch0, ch1, ch0, ch1.
REQ-036 RR=0; both channels request; s_addr_ok=1 -> ch0 wins every cycle; ch1 is granted only after m_req[0] drops.
REQ-037 ch1 requests at addr 0x1000 with s_addr_ok=0 for 3 cycles, ch0 raises its request in cycle 2 -> s_addr stays 0x1000 until accept; m_addr_ok[1] is high only in the accept cycle.
REQ-038 DEPTH=4; 4 accepts with no s_data_ok -> s_req=0 while requests pending, busy=1; one s_data_ok -> head id returned, s_req re-asserts next cycle.
REQ-039 Accept order ch0, ch1, ch0 with s_rdata 0xA, 0xB, 0xC -> m_data_ok pulses on ch0, ch1, ch0 with m_rdata 0xA, 0xB, 0xC.
REQ-040 s_data_ok pulsed while idle -> proto_err=1 and stays 1; resetn low for 1 cycle mid-burst -> all outputs 0, count 0, proto_err 0.

Source files
------------

// File: rtl/mem_req_arbiter_pkg.sv
// Shared definitions for the memory request arbiter: access size
// encodings and the width of a channel id.
package mem_req_arbiter_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Bits needed to name one of n channels; never less than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/id_fifo.sv
// Ordering FIFO of channel ids for accepted requests. Push and pop in the
// same cycle leave the count unchanged while both pointers advance.
module id_fifo #(
    parameter int DEPTH = 4,
    parameter int IW    = 1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [IW-1:0]            push_id,
    input  logic                     pop,
    output logic [IW-1:0]            pop_id,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [IW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full   = (count == (PW+1)'(DEPTH));
    assign empty  = (count == '0);
    assign pop_id = mem[rd_ptr];

    // Accept a push when there is room or a pop frees a slot; allow a pop
    // on an empty FIFO only when the same cycle pushes (pass-through).
    always_comb begin
        do_push = push & (~full | pop);
        do_pop  = pop & (~empty | push);
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; entries are only read once written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_id;
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates NCH master channels onto one downstream memory port and routes
// in-order responses back to the channel that issued each request.
// Handshake: a request transfers in the cycle where s_req and s_addr_ok are
// both high; a response transfers in any cycle where s_data_ok is high.
// Once s_req is raised without s_addr_ok the chosen channel is held until
// it is accepted, so the downstream request never changes under it.
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    parameter int RR    = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NCH-1:0]    m_req,
    input  logic [NCH-1:0]    m_wr,
    input  logic [2*NCH-1:0]  m_size,
    input  logic [AW*NCH-1:0] m_addr,
    input  logic [DW*NCH-1:0] m_wdata,
    output logic [NCH-1:0]    m_addr_ok,
    output logic [NCH-1:0]    m_data_ok,
    output logic [DW-1:0]     m_rdata,
    output logic              s_req,
    output logic              s_wr,
    output logic [1:0]        s_size,
    output logic [AW-1:0]     s_addr,
    output logic [DW-1:0]     s_wdata,
    input  logic              s_addr_ok,
    input  logic              s_data_ok,
    input  logic [DW-1:0]     s_rdata,
    output logic              busy,
    output logic              proto_err
);

    localparam int CW = id_width(NCH);
    localparam int PW = $clog2(DEPTH);

    logic          lock_q;
    logic [CW-1:0] lock_id_q;
    logic [CW-1:0] rr_ptr_q;
    logic          sel_any;
    logic [CW-1:0] sel_id;
    logic          gnt_any;
    logic [CW-1:0] gnt_id;
    logic          accept;
    logic          resp_valid;
    logic [CW-1:0] resp_id;
    logic [CW-1:0] head_id;
    logic          fifo_full;
    logic          fifo_empty;
    logic [PW:0]   fifo_count;

    // Unlocked choice: scan from lowest to highest priority so the last
    // match wins; round-robin rotates the scan start to rr_ptr_q.
    always_comb begin
        sel_any = 1'b0;
        sel_id  = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            logic [CW-1:0] idx;
            idx = (RR != 0) ? CW'((int'(rr_ptr_q) + i) % NCH) : CW'(i);
            if (m_req[idx]) begin
                sel_any = 1'b1;
                sel_id  = idx;
            end
        end
    end

    // Downstream request: held channel wins over a fresh choice; the port
    // is gated while the ordering FIFO is full or reset is asserted.
    always_comb begin
        gnt_any = lock_q | sel_any;
        gnt_id  = lock_q ? lock_id_q : sel_id;
        s_req   = resetn & gnt_any & ~fifo_full;
        accept  = s_req & s_addr_ok;
        s_wr    = s_req & m_wr[gnt_id];
        s_size  = s_req ? m_size[int'(gnt_id)*2 +: 2] : 2'b00;
        s_addr  = s_req ? m_addr[int'(gnt_id)*AW +: AW] : '0;
        s_wdata = s_req ? m_wdata[int'(gnt_id)*DW +: DW] : '0;
        m_addr_ok = accept ? (NCH'(1) << gnt_id) : '0;
    end

    // Response routing; an empty FIFO with an accept in the same cycle
    // returns the response to the channel being accepted right now.
    always_comb begin
        resp_valid = resetn & s_data_ok & (~fifo_empty | accept);
        resp_id    = fifo_empty ? gnt_id : head_id;
        m_data_ok  = resp_valid ? (NCH'(1) << resp_id) : '0;
        m_rdata    = resetn ? s_rdata : '0;
        busy       = (fifo_count != '0);
    end

    // Lock, round-robin pointer and sticky protocol error.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            rr_ptr_q  <= '0;
            proto_err <= 1'b0;
        end else begin
            if (accept) begin
                lock_q   <= 1'b0;
                rr_ptr_q <= (gnt_id == CW'(NCH - 1)) ? '0 : gnt_id + 1'b1;
            end else if (s_req) begin
                lock_q    <= 1'b1;
                lock_id_q <= gnt_id;
            end
            if (s_data_ok && fifo_empty && !accept) proto_err <= 1'b1;
        end
    end

    id_fifo #(
        .DEPTH (DEPTH),
        .IW    (CW)
    ) u_id_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push    (accept),
        .push_id (gnt_id),
        .pop     (resp_valid),
        .pop_id  (head_id),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule
